square_draw_ctrl: RTL and testbench
===================================

Name: square_draw_ctrl

Overview:
Sequencer that moves the on-screen target square whenever a new location is requested. On start, it erases the currently displayed square and latches a fresh location from the random square-location picker. It then rasterises the new square into the frame-buffer pixel-write port. It sits between the game FSM (start/done) and the VGA frame-buffer writer, and owns the square's current position.

Parameters:
SQ_SIZE, 32, square edge length in pixels (power of 2, 2..64)
SCREEN_W, 640, visible width in pixels; x >= SCREEN_W is off-screen
SCREEN_H, 480, visible height in pixels; y >= SCREEN_H is off-screen

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request to relocate the square; single-cycle pulse, sampled only in IDLE
loc_x  in  11  x location from the picker; registered and stable upstream
loc_y  in  11  y location from the picker
pix_ready  in  1  frame-buffer writer accepts a pixel this cycle
pix_write  out  1  pixel-write valid
pix_x  out  11  pixel x coordinate
pix_y  out  11  pixel y coordinate
pix_color  out  1  1 = square colour, 0 = background (erase)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when relocation completes
cur_x  out  11  top-left x of the displayed square
cur_y  out  11  top-left y of the displayed square
sq_valid  out  1  a square is currently displayed

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - state = IDLE.
  - pix_write, pix_x, pix_y, pix_color, busy, done, cur_x, cur_y and sq_valid all 0.
  - Offset counters cleared.
  - Partially drawn pixels are not erased.
- States: IDLE, ERASE, LATCH, DRAW, DONE.
- IDLE:
  - start=1 with sq_valid=1 -> ERASE.
  - start=1 with sq_valid=0 -> LATCH.
  - start=0 -> stay in IDLE.
- start outside IDLE, including in the DONE cycle, is ignored. It is not queued.
- ERASE: sweeps the square at (cur_x, cur_y) with pix_color=0. At the end of the sweep -> LATCH.
- LATCH: lasts one cycle.
  - cur_x <= loc_x and cur_y <= loc_y, captured at the clock edge that ends LATCH.
  - sq_valid <= 0 while the square is being redrawn.
  - Next state is DRAW.
- DRAW: sweeps the square at (cur_x, cur_y) with pix_color=1. At the end of the sweep -> DONE.
- DONE: lasts one cycle.
  - done=1 and sq_valid <= 1.
  - Next state is IDLE.
- Sweep:
  - Offsets dx and dy run from 0 to SQ_SIZE-1 in raster order: dx fastest, dy slowest.
  - Pixel coordinate = base + offset, computed in 12 bits so there is no wrap.
  - pix_x/pix_y are the low 11 bits of that sum.
- Handshake:
  - An in-bounds pixel drives pix_write=1.
  - The offset advances only on a cycle where pix_write=1 and pix_ready=1.
  - While pix_ready=0, pix_write, pix_x, pix_y and pix_color hold stable.
  - A pixel is never dropped or duplicated.
- Clipping:
  - A pixel is off-screen if base+dx >= SCREEN_W or base+dy >= SCREEN_H.
  - An off-screen pixel drives pix_write=0 and the offset advances one per cycle regardless of pix_ready.
- Sweep end: the cycle in which offset (SQ_SIZE-1, SQ_SIZE-1) is either accepted or skipped. Every sweep therefore takes at least SQ_SIZE^2 cycles.
- Latency with pix_ready held at 1, N = SQ_SIZE^2, start sampled at edge k:
  - sq_valid=0: LATCH in cycle k+1; DRAW in cycles k+2 .. k+1+N; done=1 in cycle k+2+N.
  - sq_valid=1: ERASE adds N cycles before LATCH, so done=1 in cycle k+2+2N.
- busy is combinational from state: it is 1 from the first non-IDLE cycle through the DONE cycle.
- Loc inputs are sampled only in LATCH; their value in any other cycle is irrelevant.

Test Plan:
(Tests 2–5 run with SQ_SIZE=4 and pix_ready=1 unless stated.)
1. Reset: assert reset mid-cycle with no clock edge -> all outputs 0 immediately; release -> IDLE with busy=0.
2. First relocation:
   - Stimulus: sq_valid=0, loc=(100,50), start pulse at edge k.
   - Expected: 16 writes with color=1, x=100..103 fastest, y=50..53, in cycles k+2..k+17.
   - done=1 in cycle k+18; cur=(100,50); sq_valid=1.
3. Relocation with erase and clipping:
   - Stimulus: loc=(638,478), start pulse.
   - Expected erase: 16 color-0 writes over (100..103, 50..53).
   - Expected draw: only (638,478), (639,478), (638,479), (639,479) written; 12 skipped cycles with pix_write=0.
   - done appears exactly 2N+2 = 34 cycles after the start edge.
4. Backpressure: drop pix_ready for 3 cycles at DRAW pixel 5 -> pix_x/pix_y/pix_color/pix_write held stable; write sequence unchanged; done delayed by exactly 3 cycles.
5. Ignored start: pulse start during DRAW and during DONE -> no extra sweep; state is IDLE one cycle after DONE; cur unchanged.
6. Reset mid-DRAW: assert reset after 7 pixels -> pix_write=0 and busy=0 immediately; sq_valid=0 and cur=(0,0); the next start goes directly to LATCH with no erase.

Source files
------------

// File: rtl/square_draw_ctrl.sv
// Relocates the on-screen target square: it erases the old square, latches a new
// location and rasterises the new square into the frame-buffer pixel-write port.
module square_draw_ctrl #(
  parameter int SQ_SIZE  = 32,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] loc_x,
  input  logic [10:0] loc_y,
  input  logic        pix_ready,
  output logic        pix_write,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_color,
  output logic        busy,
  output logic        done,
  output logic [10:0] cur_x,
  output logic [10:0] cur_y,
  output logic        sq_valid
);

  // state | meaning
  // IDLE  | waiting for start
  // ERASE | sweeping the old square with background colour
  // LATCH | capturing the new location (one cycle)
  // DRAW  | sweeping the new square with square colour
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, ERASE, LATCH, DRAW, DONE} state_t;

  localparam int OW = $clog2(SQ_SIZE);
  localparam logic [OW-1:0] OMAX = OW'(SQ_SIZE - 1);

  state_t        state, state_nxt;
  logic [OW-1:0] dx, dy;
  logic [11:0]   sum_x, sum_y;
  logic          sweeping, in_bounds, advance, last;

  // 12-bit sums so a square near the right/bottom edge never wraps back on-screen
  assign sum_x     = {1'b0, cur_x} + 12'(dx);
  assign sum_y     = {1'b0, cur_y} + 12'(dy);
  assign sweeping  = (state == ERASE) || (state == DRAW);
  assign in_bounds = (sum_x < 12'(SCREEN_W)) && (sum_y < 12'(SCREEN_H));
  assign last      = (dx == OMAX) && (dy == OMAX);
  // off-screen pixels are skipped one per cycle without waiting on the writer
  assign advance   = sweeping && (!in_bounds || pix_ready);

  assign pix_write = sweeping && in_bounds;
  assign pix_x     = sweeping ? sum_x[10:0] : 11'd0;
  assign pix_y     = sweeping ? sum_y[10:0] : 11'd0;
  assign pix_color = (state == DRAW);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = sq_valid ? ERASE : LATCH;
      ERASE:   if (advance && last) state_nxt = LATCH;
      LATCH:   state_nxt = DRAW;
      DRAW:    if (advance && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // offsets wrap to zero at the end of each sweep, ready for the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      if (dx == OMAX) begin
        dx <= '0;
        dy <= dy + OW'(1);
      end else begin
        dx <= dx + OW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x    <= 11'd0;
      cur_y    <= 11'd0;
      sq_valid <= 1'b0;
    end else if (state == LATCH) begin
      cur_x    <= loc_x;
      cur_y    <= loc_y;
      sq_valid <= 1'b0;
    end else if (state == DONE) begin
      sq_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_square_draw_ctrl.sv
// Self-checking bench for square_draw_ctrl with SQ_SIZE=4: table-driven relocations,
// a pixel scoreboard, plus hand-written reset sequences.
module tb_square_draw_ctrl;

  localparam int SQ = 4;
  localparam int N  = SQ * SQ;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] loc_x = 11'd0, loc_y = 11'd0;
  logic        pix_ready = 1'b1;
  logic        pix_write, pix_color, busy, done, sq_valid;
  logic [10:0] pix_x, pix_y, cur_x, cur_y;

  square_draw_ctrl #(.SQ_SIZE(SQ), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .reset(reset), .start(start), .loc_x(loc_x), .loc_y(loc_y),
    .pix_ready(pix_ready), .pix_write(pix_write), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .busy(busy), .done(done), .cur_x(cur_x), .cur_y(cur_y),
    .sq_valid(sq_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [22:0] exp_q[$];
  int  model_valid = 0;
  int  mcx = 0, mcy = 0;
  int  draw_acc;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_square(input int bx, input int by, input int color);
    for (int yy = 0; yy < SQ; yy++)
      for (int xx = 0; xx < SQ; xx++)
        if (bx + xx < 640 && by + yy < 480)
          exp_q.push_back({11'(bx + xx), 11'(by + yy), 1'(color)});
  endtask

  // scoreboard + hold-stability monitor
  logic        prev_stall = 1'b0;
  logic [23:0] prev_out;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall)
        chk("hold_stable", int'({pix_write, pix_x, pix_y, pix_color}), int'(prev_out));
      if (pix_write && pix_ready) begin
        chk("write_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          logic [22:0] e;
          e = exp_q.pop_front();
          chk("pix_x", int'(pix_x), int'(e[22:12]));
          chk("pix_y", int'(pix_y), int'(e[11:1]));
          chk("pix_color", int'(pix_color), int'(e[0]));
        end
      end
    end
    prev_stall = pix_write && !pix_ready && !reset;
    prev_out   = {pix_write, pix_x, pix_y, pix_color};
  end

  typedef struct {
    int lx; int ly; int stall; int ign; int exp_lat;
  } vec_t;

  task automatic relocate(input vec_t v);
    int n;
    int stall_left;
    bit got;
    loc_x = 11'(v.lx);
    loc_y = 11'(v.ly);
    if (model_valid != 0) push_square(mcx, mcy, 0);
    push_square(v.lx, v.ly, 1);
    draw_acc = 0;
    stall_left = v.stall;
    n = 0;
    got = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (pix_write && pix_ready && pix_color) draw_acc++;
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
      if (pix_write && pix_color && draw_acc == 5 && stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = 1'b1;
      end
      start = (v.ign != 0) && ((n + 1 == N + 5) || (n + 1 == v.exp_lat));
    end
    chk("done_seen", int'(got), 1);
    chk("done_latency", n, v.exp_lat);
    chk("busy_in_done", int'(busy), 1);
    @(posedge clk); #1;
    start = 1'b0;
    pix_ready = 1'b1;
    mcx = v.lx; mcy = v.ly; model_valid = 1;
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    chk("done_after", int'(done), 0);
    chk("sq_valid", int'(sq_valid), 1);
    chk("cur_x", int'(cur_x), v.lx);
    chk("cur_y", int'(cur_y), v.ly);
    chk("queue_drained", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("stays_idle", int'(busy), 0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    // loc, stall cycles, stray starts, expected start-edge-to-done cycles
    vecs[0] = '{100,  50, 0, 0, N + 2};
    vecs[1] = '{638, 478, 0, 0, 2*N + 2};
    vecs[2] = '{200, 300, 3, 0, 2*N + 5};
    vecs[3] = '{ 10,  20, 0, 1, 2*N + 2};
    vecs[4] = '{637, 100, 0, 0, 2*N + 2};

    // asynchronous reset with no clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_pix_write", int'(pix_write), 0);
    chk("rst_pix_xy", int'({pix_x, pix_y, pix_color}), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    chk("rst_cur", int'({cur_x, cur_y, sq_valid}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_sq_valid", int'(sq_valid), 0);

    for (int i = 0; i < 5; i++) relocate(vecs[i]);

    // reset after 7 drawn pixels
    begin
      int n;
      loc_x = 11'd300; loc_y = 11'd200;
      push_square(mcx, mcy, 0);
      push_square(300, 200, 1);
      draw_acc = 0;
      n = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (draw_acc < 7 && n < 400) begin
        @(negedge clk);
        n++;
        if (pix_write && pix_ready && pix_color) draw_acc++;
      end
      chk("reached_7_pixels", draw_acc, 7);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_pix_write", int'(pix_write), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_sq_valid", int'(sq_valid), 0);
      chk("mid_rst_cur", int'({cur_x, cur_y}), 0);
      exp_q.delete();
      model_valid = 0;
      @(posedge clk); #1 reset = 1'b0;
    end
    relocate('{300, 200, 0, 0, N + 2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
